game_turn_controller: RTL and testbench

GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

---
 rtl/game_turn_controller.sv | 161 ++++++++++++++++
 tb/tb_game_turn_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_controller.sv
// Turn sequencer for a two-sided battleship-style game: ship-count decision, placement,
// alternating timed turns with hit tracking, and win/lose end states.
module game_turn_controller #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECONDS  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] player_amount_ships,
    input  logic       ships_decided,
    input  logic       player_place_done,
    input  logic       pc_place_done,
    input  logic       player_shot_valid,
    input  logic       player_shot_hit,
    input  logic       pc_shot_valid,
    input  logic       pc_shot_hit,
    input  logic       restart,
    output logic [2:0] state,
    output logic       decision_State,
    output logic       placing_player,
    output logic       placing_pc,
    output logic       player_turn,
    output logic       pc_turn,
    output logic [3:0] timer_sec,
    output logic [2:0] ship_count,
    output logic [2:0] player_hits,
    output logic [2:0] pc_hits,
    output logic       auto_shot,
    output logic       game_over,
    output logic       player_won
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    TURN_LOAD = 4'(TURN_SECONDS);

    typedef enum logic [2:0] {
        DECIDE       = 3'd0,
        PLACE_PLAYER = 3'd1,
        PLACE_PC     = 3'd2,
        PLAYER_TURN  = 3'd3,
        PC_TURN      = 3'd4,
        WIN          = 3'd5,
        LOSE         = 3'd6
    } state_t;

    state_t       cur_state, next_state;
    logic [TW-1:0] tick_cnt, tick_next;
    logic [3:0]   timer_next;
    logic [2:0]   ship_next, ph_next, pc_next;
    logic         auto_next;
    logic         wrap, timeout;
    logic [2:0]   player_new, pc_new;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= DECIDE;
            tick_cnt    <= '0;
            timer_sec   <= 4'd0;
            ship_count  <= 3'd0;
            player_hits <= 3'd0;
            pc_hits     <= 3'd0;
            auto_shot   <= 1'b0;
        end else begin
            cur_state   <= next_state;
            tick_cnt    <= tick_next;
            timer_sec   <= timer_next;
            ship_count  <= ship_next;
            player_hits <= ph_next;
            pc_hits     <= pc_next;
            auto_shot   <= auto_next;
        end
    end

    assign wrap       = (tick_cnt == TICK_MAX);
    assign timeout    = wrap && (timer_sec == 4'd1);
    assign player_new = (player_shot_hit && player_hits != 3'd7) ? player_hits + 3'd1 : player_hits;
    assign pc_new     = (pc_shot_hit && pc_hits != 3'd7) ? pc_hits + 3'd1 : pc_hits;

    // Timer and tick default to zero; only staying in or entering a turn keeps them alive.
    always_comb begin
        next_state = cur_state;
        tick_next  = '0;
        timer_next = 4'd0;
        ship_next  = ship_count;
        ph_next    = player_hits;
        pc_next    = pc_hits;
        auto_next  = 1'b0;
        case (cur_state)
            DECIDE: begin
                if (ships_decided && player_amount_ships >= 3'd1 && player_amount_ships <= 3'd5) begin
                    ship_next  = player_amount_ships;
                    next_state = PLACE_PLAYER;
                end
            end
            PLACE_PLAYER: begin
                if (player_place_done)
                    next_state = PLACE_PC;
            end
            PLACE_PC: begin
                if (pc_place_done) begin
                    next_state = PLAYER_TURN;
                    timer_next = TURN_LOAD;
                end
            end
            PLAYER_TURN: begin
                if (player_shot_valid) begin
                    ph_next = player_new;
                    if (player_new == ship_count) begin
                        next_state = WIN;
                    end else begin
                        next_state = PC_TURN;
                        timer_next = TURN_LOAD;
                    end
                end else if (timeout) begin
                    auto_next  = 1'b1;
                    next_state = PC_TURN;
                    timer_next = TURN_LOAD;
                end else begin
                    tick_next  = wrap ? '0 : tick_cnt + TW'(1);
                    timer_next = wrap ? timer_sec - 4'd1 : timer_sec;
                end
            end
            PC_TURN: begin
                if (pc_shot_valid) begin
                    pc_next = pc_new;
                    if (pc_new == ship_count) begin
                        next_state = LOSE;
                    end else begin
                        next_state = PLAYER_TURN;
                        timer_next = TURN_LOAD;
                    end
                end else if (timeout) begin
                    next_state = PLAYER_TURN;
                    timer_next = TURN_LOAD;
                end else begin
                    tick_next  = wrap ? '0 : tick_cnt + TW'(1);
                    timer_next = wrap ? timer_sec - 4'd1 : timer_sec;
                end
            end
            WIN, LOSE: begin
                if (restart) begin
                    next_state = DECIDE;
                    ph_next    = 3'd0;
                    pc_next    = 3'd0;
                end
            end
            default: next_state = DECIDE;
        endcase
    end

    assign state          = cur_state;
    assign decision_State = (cur_state == DECIDE);
    assign placing_player = (cur_state == PLACE_PLAYER);
    assign placing_pc     = (cur_state == PLACE_PC);
    assign player_turn    = (cur_state == PLAYER_TURN);
    assign pc_turn        = (cur_state == PC_TURN);
    assign game_over      = (cur_state == WIN) || (cur_state == LOSE);
    assign player_won     = (cur_state == WIN);

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller with a 4-tick second and a 3-second turn,
// walking through decide, placement, timed turns, win, lose, restart and reset.
module tb_game_turn_controller;

    logic       clk;
    logic       rst;
    logic [2:0] player_amount_ships;
    logic       ships_decided;
    logic       player_place_done;
    logic       pc_place_done;
    logic       player_shot_valid;
    logic       player_shot_hit;
    logic       pc_shot_valid;
    logic       pc_shot_hit;
    logic       restart;
    logic [2:0] state;
    logic       decision_State;
    logic       placing_player;
    logic       placing_pc;
    logic       player_turn;
    logic       pc_turn;
    logic [3:0] timer_sec;
    logic [2:0] ship_count;
    logic [2:0] player_hits;
    logic [2:0] pc_hits;
    logic       auto_shot;
    logic       game_over;
    logic       player_won;

    int checks = 0;
    int errors = 0;

    game_turn_controller #(.TICKS_PER_SEC(4), .TURN_SECONDS(3)) dut (
        .clk(clk), .rst(rst),
        .player_amount_ships(player_amount_ships), .ships_decided(ships_decided),
        .player_place_done(player_place_done), .pc_place_done(pc_place_done),
        .player_shot_valid(player_shot_valid), .player_shot_hit(player_shot_hit),
        .pc_shot_valid(pc_shot_valid), .pc_shot_hit(pc_shot_hit),
        .restart(restart), .state(state),
        .decision_State(decision_State), .placing_player(placing_player),
        .placing_pc(placing_pc), .player_turn(player_turn), .pc_turn(pc_turn),
        .timer_sec(timer_sec), .ship_count(ship_count),
        .player_hits(player_hits), .pc_hits(pc_hits),
        .auto_shot(auto_shot), .game_over(game_over), .player_won(player_won)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        player_amount_ships = 3'd0;
        ships_decided = 1'b0;
        player_place_done = 1'b0;
        pc_place_done = 1'b0;
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        pc_shot_valid = 1'b0;
        pc_shot_hit = 1'b0;
        restart = 1'b0;

        apply_stimulus(2);
        rst = 1'b1;
        check_output("rst_state", state, 0);
        check_output("rst_decision", decision_State, 1);
        check_output("rst_timer", timer_sec, 0);
        check_output("rst_ships", ship_count, 0);
        check_output("rst_phits", player_hits, 0);
        check_output("rst_pchits", pc_hits, 0);
        check_output("rst_auto", auto_shot, 0);
        check_output("rst_over", game_over, 0);
        check_output("rst_won", player_won, 0);

        // Invalid ship counts stay in DECIDE, a valid one latches
        ships_decided = 1'b1;
        player_amount_ships = 3'd0;
        apply_stimulus(1);
        check_output("amt0_state", state, 0);
        player_amount_ships = 3'd6;
        apply_stimulus(1);
        check_output("amt6_state", state, 0);
        player_amount_ships = 3'd2;
        apply_stimulus(1);
        ships_decided = 1'b0;
        check_output("amt2_state", state, 1);
        check_output("amt2_ships", ship_count, 2);
        check_output("amt2_flag", placing_player, 1);
        check_output("amt2_decision", decision_State, 0);

        pc_place_done = 1'b1;
        apply_stimulus(1);
        pc_place_done = 1'b0;
        check_output("wrong_done_state", state, 1);
        player_place_done = 1'b1;
        apply_stimulus(1);
        player_place_done = 1'b0;
        check_output("place_pc_state", state, 2);
        check_output("place_pc_flag", placing_pc, 1);
        check_output("place_timer", timer_sec, 0);
        pc_place_done = 1'b1;
        apply_stimulus(1);
        pc_place_done = 1'b0;
        check_output("turn1_state", state, 3);
        check_output("turn1_timer", timer_sec, 3);
        check_output("turn1_flag", player_turn, 1);

        pc_shot_valid = 1'b1;
        pc_shot_hit = 1'b1;
        apply_stimulus(1);
        pc_shot_valid = 1'b0;
        pc_shot_hit = 1'b0;
        check_output("opp_shot_pchits", pc_hits, 0);
        check_output("opp_shot_state", state, 3);

        player_shot_valid = 1'b1;
        player_shot_hit = 1'b1;
        apply_stimulus(1);
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        check_output("hit1_phits", player_hits, 1);
        check_output("hit1_state", state, 4);
        check_output("hit1_timer", timer_sec, 3);
        check_output("hit1_pcflag", pc_turn, 1);
        check_output("hit1_auto", auto_shot, 0);

        player_shot_valid = 1'b1;
        player_shot_hit = 1'b1;
        apply_stimulus(1);
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        check_output("pcturn_opp_phits", player_hits, 1);
        check_output("pcturn_opp_state", state, 4);

        pc_shot_valid = 1'b1;
        apply_stimulus(1);
        pc_shot_valid = 1'b0;
        check_output("pcmiss_pchits", pc_hits, 0);
        check_output("pcmiss_state", state, 3);
        check_output("pcmiss_timer", timer_sec, 3);

        // Player timeout: 3 seconds of 4 ticks, auto_shot on the 12th edge after entry
        apply_stimulus(3);
        check_output("to_k3_timer", timer_sec, 3);
        apply_stimulus(1);
        check_output("to_k4_timer", timer_sec, 2);
        apply_stimulus(4);
        check_output("to_k8_timer", timer_sec, 1);
        apply_stimulus(3);
        check_output("to_k11_state", state, 3);
        check_output("to_k11_auto", auto_shot, 0);
        apply_stimulus(1);
        check_output("to_k12_auto", auto_shot, 1);
        check_output("to_k12_state", state, 4);
        check_output("to_k12_timer", timer_sec, 3);
        check_output("to_k12_phits", player_hits, 1);
        apply_stimulus(1);
        check_output("to_k13_auto", auto_shot, 0);

        // PC timeout returns to the player without a hit or auto_shot
        apply_stimulus(10);
        check_output("pcto_k11_state", state, 4);
        apply_stimulus(1);
        check_output("pcto_state", state, 3);
        check_output("pcto_auto", auto_shot, 0);
        check_output("pcto_pchits", pc_hits, 0);
        check_output("pcto_timer", timer_sec, 3);

        // Shot lands on the timeout cycle and wins the game
        apply_stimulus(11);
        check_output("race_pre_timer", timer_sec, 1);
        player_shot_valid = 1'b1;
        player_shot_hit = 1'b1;
        apply_stimulus(1);
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        check_output("win_state", state, 5);
        check_output("win_auto", auto_shot, 0);
        check_output("win_phits", player_hits, 2);
        check_output("win_over", game_over, 1);
        check_output("win_won", player_won, 1);
        check_output("win_timer", timer_sec, 0);
        check_output("win_flags", {decision_State, placing_player, placing_pc, player_turn, pc_turn}, 0);

        player_shot_valid = 1'b1;
        player_shot_hit = 1'b1;
        pc_shot_valid = 1'b1;
        pc_shot_hit = 1'b1;
        apply_stimulus(2);
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        pc_shot_valid = 1'b0;
        pc_shot_hit = 1'b0;
        check_output("win_hold_state", state, 5);
        check_output("win_hold_phits", player_hits, 2);
        check_output("win_hold_pchits", pc_hits, 0);

        restart = 1'b1;
        apply_stimulus(1);
        restart = 1'b0;
        check_output("rs_win_state", state, 0);
        check_output("rs_win_phits", player_hits, 0);
        check_output("rs_win_ships", ship_count, 2);

        // Second game with one ship ends in LOSE
        ships_decided = 1'b1;
        player_amount_ships = 3'd1;
        apply_stimulus(1);
        ships_decided = 1'b0;
        check_output("g2_ships", ship_count, 1);
        restart = 1'b1;
        apply_stimulus(1);
        restart = 1'b0;
        check_output("g2_restart_ignored", state, 1);
        player_place_done = 1'b1;
        apply_stimulus(1);
        player_place_done = 1'b0;
        pc_place_done = 1'b1;
        apply_stimulus(1);
        pc_place_done = 1'b0;
        check_output("g2_turn_state", state, 3);
        player_shot_valid = 1'b1;
        apply_stimulus(1);
        player_shot_valid = 1'b0;
        check_output("g2_miss_phits", player_hits, 0);
        check_output("g2_miss_state", state, 4);
        pc_shot_valid = 1'b1;
        pc_shot_hit = 1'b1;
        apply_stimulus(1);
        pc_shot_valid = 1'b0;
        pc_shot_hit = 1'b0;
        check_output("lose_state", state, 6);
        check_output("lose_pchits", pc_hits, 1);
        check_output("lose_over", game_over, 1);
        check_output("lose_won", player_won, 0);
        restart = 1'b1;
        apply_stimulus(1);
        restart = 1'b0;
        check_output("rs_lose_state", state, 0);
        check_output("rs_lose_pchits", pc_hits, 0);
        check_output("rs_lose_ships", ship_count, 1);

        // Third game: reset in the middle of a PC turn
        ships_decided = 1'b1;
        player_amount_ships = 3'd3;
        apply_stimulus(1);
        ships_decided = 1'b0;
        player_place_done = 1'b1;
        apply_stimulus(1);
        player_place_done = 1'b0;
        pc_place_done = 1'b1;
        apply_stimulus(1);
        pc_place_done = 1'b0;
        player_shot_valid = 1'b1;
        player_shot_hit = 1'b1;
        apply_stimulus(1);
        player_shot_valid = 1'b0;
        player_shot_hit = 1'b0;
        apply_stimulus(2);
        check_output("g3_mid_state", state, 4);
        check_output("g3_mid_phits", player_hits, 1);
        rst = 1'b0;
        apply_stimulus(1);
        rst = 1'b1;
        check_output("midrst_state", state, 0);
        check_output("midrst_decision", decision_State, 1);
        check_output("midrst_ships", ship_count, 0);
        check_output("midrst_phits", player_hits, 0);
        check_output("midrst_timer", timer_sec, 0);
        apply_stimulus(1);
        check_output("midrst_hold_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
